mcp3202_sample_scheduler: RTL and testbench

Sequencer sitting above the MCP3202 SPI conversion engine: generates the sample-rate tick and picks CH0/CH1 round-robin from an enable mask. It issues one conversion per tick with the correct SGL/ODD configuration, then tags each 12-bit result with its channel. Results go downstream over a valid/ready handshake, with sticky status for missed ticks and overwritten results.

---
 rtl/mcp3202_sample_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_mcp3202_sample_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcp3202_sample_scheduler.sv
// Sample-rate sequencer for the MCP3202 SPI engine: round-robin CH0/CH1 conversions, tagged results, sticky status.
// Optional build macro SCHED_TIMEOUT_EN adds a conversion watchdog and the o_timeout port.
module mcp3202_sample_scheduler #(
  parameter int unsigned SAMPLE_DIV = 2500,
  parameter int unsigned TIMEOUT    = 4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [1:0]  i_chan_mask,
  input  logic        i_diff,
  output logic        o_start,
  output logic        o_sgl,
  output logic        o_odd,
  input  logic        i_done,
  input  logic [11:0] i_data,
  output logic [11:0] o_data,
  output logic        o_chan,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_tick_miss,
  output logic        o_overrun,
`ifdef SCHED_TIMEOUT_EN
  output logic        o_timeout,
`endif
  input  logic        i_clr_status
);

  typedef enum logic [1:0] {IDLE, WAIT_TICK, CONVERT} state_e;

  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        start_q, start_d;
  logic        chan_q, chan_d;
  logic        sgl_q, sgl_d;
  logic        last_q, last_d;
  logic [11:0] data_q, data_d;
  logic        ochan_q, ochan_d;
  logic        valid_q, valid_d;
  logic        miss_q, miss_d;
  logic        ovr_q, ovr_d;
  logic        tick;
  logic        pick_chan;
  logic        pick_ok;

`ifdef SCHED_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
  logic [31:0] tmo_q, tmo_d;
  logic        tmof_q, tmof_d;
`endif

  always_comb begin
    cnt_d = '0;
    if (i_enable) begin
      cnt_d = (cnt_q == DIV_LAST) ? '0 : cnt_q + 16'd1;
    end
  end

  assign tick    = (cnt_q == DIV_LAST);
  assign pick_ok = |i_chan_mask;

  // Prefer the channel not served last; fall back to whichever one is enabled.
  always_comb begin
    pick_chan = 1'b1;
    if (!last_q && i_chan_mask[1]) begin
      pick_chan = 1'b1;
    end else if (i_chan_mask[0]) begin
      pick_chan = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    chan_d  = chan_q;
    sgl_d   = sgl_q;
    last_d  = last_q;
    data_d  = data_q;
    ochan_d = ochan_q;
    valid_d = valid_q & ~i_ready;
    miss_d  = miss_q & ~i_clr_status;
    ovr_d   = ovr_q & ~i_clr_status;
`ifdef SCHED_TIMEOUT_EN
    tmo_d   = '0;
    tmof_d  = tmof_q & ~i_clr_status;
`endif
    case (state_q)
      IDLE: begin
        if (i_enable) begin
          state_d = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (!i_enable) begin
          state_d = IDLE;
        end else if (tick && pick_ok) begin
          chan_d  = pick_chan;
          sgl_d   = ~i_diff;
          start_d = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (tick && pick_ok) begin
          miss_d = 1'b1;
        end
`ifdef SCHED_TIMEOUT_EN
        tmo_d = tmo_q + 32'd1;
`endif
        if (i_done) begin
          data_d  = i_data;
          ochan_d = chan_q;
          valid_d = 1'b1;
          last_d  = chan_q;
          if (valid_q && !i_ready) begin
            ovr_d = 1'b1;
          end
          state_d = i_enable ? WAIT_TICK : IDLE;
        end
`ifdef SCHED_TIMEOUT_EN
        // Abandon a silent engine and move past the failed channel.
        else if (tmo_q == TMO_LAST) begin
          tmof_d  = 1'b1;
          last_d  = chan_q;
          state_d = i_enable ? WAIT_TICK : IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      chan_q  <= 1'b0;
      sgl_q   <= 1'b1;
      last_q  <= 1'b1;
      data_q  <= '0;
      ochan_q <= 1'b0;
      valid_q <= 1'b0;
      miss_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      tmo_q   <= '0;
      tmof_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      chan_q  <= chan_d;
      sgl_q   <= sgl_d;
      last_q  <= last_d;
      data_q  <= data_d;
      ochan_q <= ochan_d;
      valid_q <= valid_d;
      miss_q  <= miss_d;
      ovr_q   <= ovr_d;
`ifdef SCHED_TIMEOUT_EN
      tmo_q   <= tmo_d;
      tmof_q  <= tmof_d;
`endif
    end
  end

  assign o_start     = start_q;
  assign o_sgl       = sgl_q;
  assign o_odd       = chan_q;
  assign o_data      = data_q;
  assign o_chan      = ochan_q;
  assign o_valid     = valid_q;
  assign o_tick_miss = miss_q;
  assign o_overrun   = ovr_q;
`ifdef SCHED_TIMEOUT_EN
  assign o_timeout   = tmof_q;
`endif

endmodule

// File: tb/tb_mcp3202_sample_scheduler.sv
// Directed bench for mcp3202_sample_scheduler with a behavioural engine that answers a fixed delay after o_start.
// Timeout steps are built only when SCHED_TIMEOUT_EN is defined.
module tb_mcp3202_sample_scheduler;

  localparam int DIV = 100;
  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic [1:0]  i_chan_mask;
  logic        i_diff;
  logic        o_start;
  logic        o_sgl;
  logic        o_odd;
  logic        i_done;
  logic [11:0] i_data;
  logic [11:0] o_data;
  logic        o_chan;
  logic        o_valid;
  logic        i_ready;
  logic        o_tick_miss;
  logic        o_overrun;
  logic        i_clr_status;
`ifdef SCHED_TIMEOUT_EN
  logic        o_timeout;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          engDelay = 40;
  int          engD;
  int          engK;
  logic        engMute = 1'b0;
  logic [11:0] engData = '0;

  mcp3202_sample_scheduler #(.SAMPLE_DIV(DIV), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_chan_mask(i_chan_mask), .i_diff(i_diff),
    .o_start(o_start), .o_sgl(o_sgl), .o_odd(o_odd), .i_done(i_done), .i_data(i_data),
    .o_data(o_data), .o_chan(o_chan), .o_valid(o_valid), .i_ready(i_ready),
    .o_tick_miss(o_tick_miss), .o_overrun(o_overrun),
`ifdef SCHED_TIMEOUT_EN
    .o_timeout(o_timeout),
`endif
    .i_clr_status(i_clr_status)
  );

  initial forever #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: i_done pulses engDelay clocks after o_start is seen; a reset abandons the conversion.
  initial begin
    i_done = 1'b0;
    i_data = '0;
    forever begin
      @(negedge clk);
      if (!rst && o_start && !engMute) begin
        engD = engDelay;
        engK = 0;
        while (engK < engD && !rst) begin
          @(negedge clk);
          engK++;
        end
        if (!rst) begin
          i_data = engData;
          i_done = 1'b1;
          @(negedge clk);
          i_done = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sigVal(input int sel);
    case (sel)
      0: return o_start;
      1: return o_valid;
      2: return o_tick_miss;
`ifdef SCHED_TIMEOUT_EN
      4: return o_timeout;
`endif
      default: return o_overrun;
    endcase
  endfunction

  task automatic waitSig(input string tag, input int sel, input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (sigVal(sel) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    checkOutput({tag, "Seen"}, 32'(at >= 0), 32'd1);
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] mask, input logic diff);
    i_enable    = en;
    i_chan_mask = mask;
    i_diff      = diff;
  endtask

  task automatic pulseClear();
    i_clr_status = 1'b1;
    @(negedge clk);
    i_clr_status = 1'b0;
  endtask

  initial begin
    int tEn, tS, tPrev, tV, tM, s1, s2, nStart;
    rst = 1'b1;
    i_ready = 1'b1;
    i_clr_status = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rstStart", 32'(o_start), 32'd0);
    checkOutput("rstSgl", 32'(o_sgl), 32'd1);
    checkOutput("rstOdd", 32'(o_odd), 32'd0);
    checkOutput("rstData", 32'(o_data), 32'd0);
    checkOutput("rstChan", 32'(o_chan), 32'd0);
    checkOutput("rstValid", 32'(o_valid), 32'd0);
    checkOutput("rstFlags", 32'({o_tick_miss, o_overrun}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifdef SCHED_TIMEOUT_EN
    $display("[TB] watchdog: engine silent");
    engMute = 1'b1;
    applyStimulus(1'b1, 2'b11, 1'b0);
    waitSig("tmoStart", 0, 150, tS);
    checkOutput("tmoOdd0", 32'(o_odd), 32'd0);
    waitSig("tmoFlag", 4, 100, tM);
    checkOutput("tmoLatency", 32'(tM - tS), 32'd50);
    checkOutput("tmoNoValid", 32'(o_valid), 32'd0);
    waitSig("tmoNext", 0, 100, tV);
    checkOutput("tmoNextPeriod", 32'(tV - tS), 32'd100);
    checkOutput("tmoOtherChan", 32'(o_odd), 32'd1);
    pulseClear();
    checkOutput("tmoClear", 32'(o_timeout), 32'd0);
    applyStimulus(1'b0, 2'b11, 1'b0);
    engMute = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    $display("[TB] round robin, single-ended");
    engDelay = 40;
    applyStimulus(1'b1, 2'b11, 1'b0);
    tEn = cyc;
    tPrev = tEn;
    for (int i = 0; i < 4; i++) begin
      engData = 12'h100 + 12'(i);
      waitSig("rrStart", 0, 150, tS);
      checkOutput("rrPeriod", 32'(tS - tPrev), 32'd100);
      checkOutput("rrSgl", 32'(o_sgl), 32'd1);
      checkOutput("rrOdd", 32'(o_odd), 32'(i % 2));
      @(negedge clk);
      checkOutput("rrStartPulse", 32'(o_start), 32'd0);
      waitSig("rrValid", 1, 60, tV);
      checkOutput("rrLatency", 32'(tV - tS), 32'd41);
      checkOutput("rrData", 32'(o_data), 32'h100 + 32'(i));
      checkOutput("rrChan", 32'(o_chan), 32'(i % 2));
      @(negedge clk);
      checkOutput("rrAccepted", 32'(o_valid), 32'd0);
      tPrev = tS;
    end
    checkOutput("rrNoFlags", 32'({o_tick_miss, o_overrun}), 32'd0);

    $display("[TB] CH1 only, differential");
    applyStimulus(1'b1, 2'b10, 1'b1);
    for (int j = 0; j < 2; j++) begin
      engData = 12'h200 + 12'(j);
      waitSig("diffStart", 0, 150, tS);
      checkOutput("diffSgl", 32'(o_sgl), 32'd0);
      checkOutput("diffOdd", 32'(o_odd), 32'd1);
      waitSig("diffValid", 1, 60, tV);
      checkOutput("diffData", 32'(o_data), 32'h200 + 32'(j));
      checkOutput("diffChan", 32'(o_chan), 32'd1);
    end

    $display("[TB] slow engine, tick miss");
    @(negedge clk);
    applyStimulus(1'b1, 2'b11, 1'b0);
    engDelay = 150;
    engData = 12'h300;
    waitSig("slowStart1", 0, 150, s1);
    checkOutput("slowOdd1", 32'(o_odd), 32'd0);
    waitSig("slowMiss1", 2, 120, tM);
    checkOutput("slowMissAt", 32'(tM - s1), 32'd100);
    waitSig("slowStart2", 0, 150, s2);
    checkOutput("slowPeriod", 32'(s2 - s1), 32'd200);
    checkOutput("slowOdd2", 32'(o_odd), 32'd1);
    pulseClear();
    checkOutput("missCleared", 32'(o_tick_miss), 32'd0);
    waitSig("slowMiss2", 2, 120, tM);
    checkOutput("slowMissAgain", 32'(tM - s2), 32'd100);
    engDelay = 40;
    waitSig("slowValid", 1, 100, tV);
    checkOutput("slowLatency", 32'(tV - s2), 32'd151);
    checkOutput("slowData", 32'(o_data), 32'h300);

    $display("[TB] overrun");
    @(negedge clk);
    checkOutput("ovrPreValid", 32'(o_valid), 32'd0);
    i_ready = 1'b0;
    engData = 12'h123;
    waitSig("ovrStart1", 0, 150, tS);
    repeat (41) @(negedge clk);
    checkOutput("ovrFirstData", 32'(o_data), 32'h123);
    checkOutput("ovrFirstFlag", 32'(o_overrun), 32'd0);
    engData = 12'hABC;
    waitSig("ovrStart2", 0, 100, tS);
    repeat (41) @(negedge clk);
    checkOutput("ovrData", 32'(o_data), 32'hABC);
    checkOutput("ovrChan", 32'(o_chan), 32'd1);
    checkOutput("ovrValid", 32'(o_valid), 32'd1);
    checkOutput("ovrFlag", 32'(o_overrun), 32'd1);
    i_ready = 1'b1;
    @(negedge clk);
    checkOutput("ovrAccepted", 32'(o_valid), 32'd0);
    pulseClear();
    checkOutput("ovrCleared", 32'({o_tick_miss, o_overrun}), 32'd0);
    i_ready = 1'b0;
    engData = 12'h111;
    waitSig("sameStart1", 0, 100, tS);
    repeat (41) @(negedge clk);
    checkOutput("sameFirst", 32'({o_valid, o_data}), {19'd0, 1'b1, 12'h111});
    engData = 12'h222;
    waitSig("sameStart2", 0, 100, tS);
    repeat (40) @(negedge clk);
    i_ready = 1'b1;
    @(negedge clk);
    checkOutput("sameValid", 32'(o_valid), 32'd1);
    checkOutput("sameData", 32'(o_data), 32'h222);
    checkOutput("sameNoOverrun", 32'(o_overrun), 32'd0);
    @(negedge clk);
    checkOutput("sameAccepted", 32'(o_valid), 32'd0);

    $display("[TB] disable mid-conversion");
    engData = 12'h3C5;
    waitSig("disStart", 0, 150, tS);
    repeat (10) @(negedge clk);
    i_enable = 1'b0;
    waitSig("disValid", 1, 60, tV);
    checkOutput("disLatency", 32'(tV - tS), 32'd41);
    checkOutput("disData", 32'(o_data), 32'h3C5);
    nStart = 0;
    repeat (250) begin
      @(negedge clk);
      if (o_start) nStart++;
    end
    checkOutput("disNoStart", 32'(nStart), 32'd0);

    $display("[TB] reset mid-conversion");
    engData = 12'h7E7;
    tEn = cyc;
    applyStimulus(1'b1, 2'b10, 1'b1);
    waitSig("rstMidStart", 0, 150, tS);
    checkOutput("enableLatency", 32'(tS - tEn), 32'd100);
    checkOutput("rstMidPreOdd", 32'({o_sgl, o_odd}), 32'b01);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstMidStartOut", 32'(o_start), 32'd0);
    checkOutput("rstMidCfg", 32'({o_sgl, o_odd}), 32'b10);
    checkOutput("rstMidData", 32'({o_chan, o_valid, o_data}), 32'd0);
    checkOutput("rstMidFlags", 32'({o_tick_miss, o_overrun}), 32'd0);
    i_enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    nStart = 0;
    repeat (150) begin
      @(negedge clk);
      if (o_start || o_valid) nStart++;
    end
    checkOutput("postRstQuiet", 32'(nStart), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
